cnn_batch_norm_weights_loader: RTL and testbench
================================================

CNN_BATCH_NORM_WEIGHTS_LOADER -- requirements
Module: cnn_batch_norm_weights_loader

Interface
REQ-001 Parameter OUTPUT_BRAM_NUM, default 4, number of batch-norm weight BRAMs filled, in index order.
REQ-002 Parameter DATA_WIDTH, default 32, width of one weight word.
REQ-003 Parameter BATCH_NORM_WEIGHTS_WIDTH, default 8, width of the size input and of each byte-address data point.
REQ-004 i_clock  in  1  single clock; all logic is on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle load request, sampled only in IDLE.
REQ-007 i_batch_norm_weights_size  in  BATCH_NORM_WEIGHTS_WIDTH  number of words per BRAM, latched on accepted start.
REQ-008 i_reset_busy  in  1  OR of the BRAM rsta_busy flags.
REQ-009 i_s_valid  in  1  input word valid.
REQ-010 i_s_data  in  DATA_WIDTH  input weight word.
REQ-011 o_s_ready  out  1  loader accepts a word this cycle.
REQ-012 o_enable  out  1  BRAM port enable.
REQ-013 o_wenable  out  OUTPUT_BRAM_NUM  one-hot per-BRAM write enable; bit i drives BRAM i.
REQ-014 o_bram_data  out  DATA_WIDTH  write data shared by all BRAMs.
REQ-015 o_batch_norm_weights_data_point  out  OUTPUT_BRAM_NUM*BATCH_NORM_WEIGHTS_WIDTH  per-BRAM byte address; slice i drives BRAM i.
REQ-016 o_busy  out  1  high whenever the state is not IDLE.
REQ-017 o_done  out  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_RST, LOAD and DONE.
REQ-019 IDLE -> WAIT_RST on i_start; i_start outside IDLE SHALL be ignored.
REQ-020 At an accepted start, size SHALL be latched, saturated to 2^(BATCH_NORM_WEIGHTS_WIDTH-2) (64 at default), and the BRAM index and word index cleared.
REQ-021 A latched size of 0 SHALL go WAIT_RST -> DONE with no writes; otherwise WAIT_RST -> LOAD once i_reset_busy is low.
REQ-022 o_s_ready SHALL equal (state==LOAD && !i_reset_busy).
REQ-023 A word is accepted on a cycle where i_s_valid && o_s_ready.
REQ-024 Each accepted word SHALL produce a write on the next cycle (1-cycle latency) on the registered outputs:
  - o_wenable bit b = 1, all other bits 0;
  - o_bram_data = the accepted word;
  - data_point slice b = 4 * word index.
REQ-025 Data-point slices of non-written BRAMs SHALL hold their values, and o_wenable SHALL be all-zero on cycles with no accepted word.
REQ-026 After each accept, the word index SHALL increment; on reaching size it SHALL wrap to 0 and the BRAM index SHALL increment.
REQ-027 After the accept of word size-1 into BRAM OUTPUT_BRAM_NUM-1, the state SHALL go LOAD -> DONE and o_s_ready SHALL be low from the next cycle.
REQ-028 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE.
  - Timing: o_done coincides with the final o_wenable pulse.
  - Size 0: o_done occurs the cycle after WAIT_RST.
REQ-029 o_enable SHALL be 1 in WAIT_RST, LOAD and DONE, and 0 in IDLE.
REQ-030 i_reset_busy rising mid-LOAD SHALL stall acceptance with no loss or duplication of words, and indices SHALL hold.
REQ-031 Address arithmetic SHALL be at BATCH_NORM_WEIGHTS_WIDTH bits; saturation guarantees 4*(size-1) never overflows.

Reset
REQ-032 While i_reset is high, asynchronously and regardless of state:
  - state = IDLE; all indices and latched size = 0;
  - o_s_ready, o_enable, o_wenable, o_busy, o_done = 0;
  - o_bram_data = 0 and all data points = 0.
REQ-033 Reset mid-LOAD SHALL abandon the load, and a following i_start SHALL restart from BRAM 0, word 0.

Verification
REQ-034 Size=3, i_reset_busy=0, valid held high with words 0xA0..0xAB -> 12 writes on consecutive cycles:
  - BRAM0 gets 0xA0..0xA2 at data_point 0,4,8; BRAM1 gets 0xA3..0xA5; and so on;
  - o_done coincides with the write of 0xAB.
REQ-035 Size=0 with i_start -> no o_wenable pulse, o_done 2 cycles after start, o_busy low afterwards.
REQ-036 Size=200 -> saturates to 64; the last write per BRAM is at data_point 252; 256 writes in total.
REQ-037 i_reset_busy high for 5 cycles after start, then a 2-cycle pulse mid-load -> o_s_ready low exactly during busy; all 12 words (size=3) are written in order, once each.
REQ-038 Valid toggling 1/0 -> writes occur only one cycle after accepted beats, with o_wenable all-zero between them.
REQ-039 i_reset asserted after 5 writes, then released and restarted -> all outputs 0 immediately; the new load writes BRAM0 from data_point 0; i_start during LOAD is ignored.

Source files
------------

// File: rtl/cnn_batch_norm_weights_loader.sv
// Batch-norm weights loader: streams input words into OUTPUT_BRAM_NUM BRAMs in
// index order, `size` words per BRAM. Each BRAM gets byte addresses 0,4,8,...
module cnn_batch_norm_weights_loader #(
    parameter int unsigned OUTPUT_BRAM_NUM          = 4,
    parameter int unsigned DATA_WIDTH               = 32,
    parameter int unsigned BATCH_NORM_WEIGHTS_WIDTH = 8
) (
    input  logic                                                i_clock,
    input  logic                                                i_reset,
    input  logic                                                i_start,
    input  logic [BATCH_NORM_WEIGHTS_WIDTH-1:0]                 i_batch_norm_weights_size,
    input  logic                                                i_reset_busy,
    input  logic                                                i_s_valid,
    input  logic [DATA_WIDTH-1:0]                               i_s_data,
    output logic                                                o_s_ready,
    output logic                                                o_enable,
    output logic [OUTPUT_BRAM_NUM-1:0]                          o_wenable,
    output logic [DATA_WIDTH-1:0]                               o_bram_data,
    output logic [OUTPUT_BRAM_NUM*BATCH_NORM_WEIGHTS_WIDTH-1:0] o_batch_norm_weights_data_point,
    output logic                                                o_busy,
    output logic                                                o_done
);

    localparam int unsigned SW       = BATCH_NORM_WEIGHTS_WIDTH;
    localparam int unsigned BIDX_W   = (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1;
    localparam int unsigned SIZE_MAX = 1 << (SW - 2);

    localparam logic [SW-1:0]     SIZE_MAX_V = SW'(SIZE_MAX);
    localparam logic [BIDX_W-1:0] LAST_BRAM  = BIDX_W'(OUTPUT_BRAM_NUM - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RST = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                    state_q;
    logic [SW-1:0]             size_q;
    logic [SW-1:0]             word_idx_q;
    logic [BIDX_W-1:0]         bram_idx_q;
    logic [OUTPUT_BRAM_NUM-1:0] wenable_q;
    logic [DATA_WIDTH-1:0]     bram_data_q;
    logic [SW-1:0]             dp_q [OUTPUT_BRAM_NUM];
    logic                      busy_q;
    logic                      enable_q;
    logic                      done_q;

    logic [SW-1:0]             size_sat_d;
    logic [SW-1:0]             word_idx_d;
    logic                      last_word_d;
    logic                      accept_d;

    // Size saturation keeps 4*(size-1) inside SW bits; handshake and wrap detect.
    always_comb begin
        size_sat_d  = (i_batch_norm_weights_size > SIZE_MAX_V) ? SIZE_MAX_V : i_batch_norm_weights_size;
        word_idx_d  = word_idx_q + SW'(1);
        last_word_d = (word_idx_d == size_q);
        accept_d    = i_s_valid && (state_q == LOAD) && !i_reset_busy;
    end

    assign o_s_ready   = (state_q == LOAD) && !i_reset_busy;
    assign o_enable    = enable_q;
    assign o_wenable   = wenable_q;
    assign o_bram_data = bram_data_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    for (genvar gi = 0; gi < OUTPUT_BRAM_NUM; gi++) begin : g_dp
        assign o_batch_norm_weights_data_point[gi*SW +: SW] = dp_q[gi];
    end

    // Control FSM with registered write port, status and completion pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            size_q      <= '0;
            word_idx_q  <= '0;
            bram_idx_q  <= '0;
            wenable_q   <= '0;
            bram_data_q <= '0;
            busy_q      <= 1'b0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < OUTPUT_BRAM_NUM; i++) begin
                dp_q[i] <= '0;
            end
        end else begin
            wenable_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        size_q     <= size_sat_d;
                        word_idx_q <= '0;
                        bram_idx_q <= '0;
                        busy_q     <= 1'b1;
                        enable_q   <= 1'b1;
                        state_q    <= WAIT_RST;
                    end
                end
                WAIT_RST: begin
                    if (size_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (!i_reset_busy) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept_d) begin
                        wenable_q           <= OUTPUT_BRAM_NUM'(1) << bram_idx_q;
                        bram_data_q         <= i_s_data;
                        dp_q[bram_idx_q]    <= SW'({word_idx_q, 2'b00});
                        if (last_word_d) begin
                            word_idx_q <= '0;
                            if (bram_idx_q == LAST_BRAM) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                bram_idx_q <= bram_idx_q + BIDX_W'(1);
                            end
                        end else begin
                            word_idx_q <= word_idx_d;
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    enable_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_batch_norm_weights_loader.sv
// Scoreboard bench for cnn_batch_norm_weights_loader.
module tb_cnn_batch_norm_weights_loader;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 8;
    localparam int          SMAX = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [SW-1:0]     i_size = '0;
    logic              rst_busy = 1'b0;
    logic              i_s_valid = 1'b0;
    logic [DW-1:0]     i_s_data = '0;
    logic              o_s_ready;
    logic              o_enable;
    logic [N-1:0]      o_wenable;
    logic [DW-1:0]     o_bram_data;
    logic [N*SW-1:0]   o_dp;
    logic              o_busy;
    logic              o_done;

    cnn_batch_norm_weights_loader #(
        .OUTPUT_BRAM_NUM(N),
        .DATA_WIDTH(DW),
        .BATCH_NORM_WEIGHTS_WIDTH(SW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_start(i_start),
        .i_batch_norm_weights_size(i_size),
        .i_reset_busy(rst_busy),
        .i_s_valid(i_s_valid),
        .i_s_data(i_s_data),
        .o_s_ready(o_s_ready),
        .o_enable(o_enable),
        .o_wenable(o_wenable),
        .o_bram_data(o_bram_data),
        .o_batch_norm_weights_data_point(o_dp),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  wen;
        logic [DW-1:0] data;
        int            bram;
        logic [SW-1:0] dp;
        logic          done;
    } exp_t;

    exp_t          exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    logic [SW-1:0] exp_dp [N];
    logic          acc_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals done.
    always @(negedge clk) begin
        exp_t            e;
        logic [N*SW-1:0] edp;
        if (rst) begin
            acc_prev = 1'b0;
            for (int i = 0; i < N; i++) exp_dp[i] = '0;
        end else begin
            if (rst_busy) chk("ready_low_while_busy", 64'(o_s_ready), 64'(0));
            chk("write_one_cycle_after_accept", 64'(|o_wenable), 64'(acc_prev));
            if (|o_wenable) wr_cnt++;
            if (o_done) done_cnt++;
            if ((|o_wenable) || o_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output wen=%b done=%b required=no_output", o_wenable, o_done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.wen != '0) exp_dp[e.bram] = e.dp;
                    for (int i = 0; i < N; i++) edp[i*SW +: SW] = exp_dp[i];
                    chk("wenable", 64'(o_wenable), 64'(e.wen));
                    if (e.wen != '0) chk("bram_data", 64'(o_bram_data), 64'(e.data));
                    chk("data_points", 64'(o_dp), 64'(edp));
                    chk("done_pulse", 64'(o_done), 64'(e.done));
                    chk("busy_during_output", 64'(o_busy), 64'(1));
                    chk("enable_during_output", 64'(o_enable), 64'(1));
                end
            end
            acc_prev = i_s_valid && o_s_ready;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_s_ready), 64'(0));
        chk({tag, "_enable"}, 64'(o_enable), 64'(0));
        chk({tag, "_wenable"}, 64'(o_wenable), 64'(0));
        chk({tag, "_bram_data"}, 64'(o_bram_data), 64'(0));
        chk({tag, "_data_points"}, 64'(o_dp), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_done"}, 64'(o_done), 64'(0));
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random. bmode: 0 none, 1 5-cycle + mid pulse, 2 random.
    task automatic run_load(input int size, input int vmode, input int bmode, input bit fixed_words,
                            input int abort_after, input bit start_mid);
        int            eff;
        int            total;
        int            idx;
        int            cyc;
        int            budget;
        int            d0;
        int            w0;
        int            t;
        logic [DW-1:0] words [$];
        exp_t          e;
        eff   = (size > SMAX) ? SMAX : size;
        total = eff * N;
        for (int k = 0; k < total; k++) words.push_back(fixed_words ? DW'(32'hA0 + k) : DW'($urandom));
        for (int k = 0; k < total; k++) begin
            e.bram = k / eff;
            e.wen  = N'(1) << e.bram;
            e.data = words[k];
            e.dp   = SW'(4 * (k % eff));
            e.done = (k == total - 1);
            exp_q.push_back(e);
        end
        if (eff == 0) begin
            e.wen = '0; e.data = '0; e.bram = 0; e.dp = '0; e.done = 1'b1;
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        w0 = wr_cnt;
        @(posedge clk); #1;
        i_start  = 1'b1;
        i_size   = SW'(size);
        rst_busy = (bmode == 1);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'(1));
        chk("enable_after_start", 64'(o_enable), 64'(1));
        if (eff == 0) begin
            chk("size0_no_done_yet", 64'(o_done), 64'(0));
            @(posedge clk); #1;
            chk("size0_done_two_after_start", 64'(o_done), 64'(1));
            @(posedge clk); #1;
            chk("size0_done_one_cycle", 64'(o_done), 64'(0));
            chk("size0_busy_low_after", 64'(o_busy), 64'(0));
            chk("size0_no_writes", 64'(wr_cnt - w0), 64'(0));
            chk("size0_done_count", 64'(done_cnt - d0), 64'(1));
            return;
        end
        idx    = 0;
        cyc    = 0;
        budget = total * 10 + 40;
        while (idx < total && cyc < budget) begin
            if (abort_after > 0 && (wr_cnt - w0) >= abort_after) begin
                rst       = 1'b1;
                i_s_valid = 1'b0;
                i_start   = 1'b0;
                rst_busy  = 1'b0;
                #1;
                check_all_zero("async_reset");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            case (bmode)
                1:       rst_busy = (cyc < 5) || (cyc >= 12 && cyc < 14);
                2:       rst_busy = ($urandom_range(0, 4) == 0);
                default: rst_busy = 1'b0;
            endcase
            case (vmode)
                1:       i_s_valid = (cyc % 2 == 0);
                2:       i_s_valid = ($urandom_range(0, 1) == 1);
                default: i_s_valid = 1'b1;
            endcase
            i_start  = start_mid && (cyc == 8);
            i_s_data = words[idx];
            @(negedge clk);
            if (i_s_valid && o_s_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        i_s_valid = 1'b0;
        i_start   = 1'b0;
        rst_busy  = 1'b0;
        if (abort_after > 0) begin
            checks++;
            failures++;
            $display("FAIL abort_point_not_reached writes=%0d required=%0d", wr_cnt - w0, abort_after);
            return;
        end
        if (idx < total) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout accepted=%0d required=%0d", idx, total);
        end
        t = 0;
        while (done_cnt == d0 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_count", 64'(done_cnt - d0), 64'(1));
        chk("write_count", 64'(wr_cnt - w0), 64'(total));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("busy_low_after_done", 64'(o_busy), 64'(0));
        chk("ready_low_after_done", 64'(o_s_ready), 64'(0));
        chk("enable_low_after_done", 64'(o_enable), 64'(0));
    endtask

    initial begin
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_load(3,   0, 0, 1'b1, 0, 1'b0);
        run_load(0,   0, 0, 1'b0, 0, 1'b0);
        run_load(200, 2, 2, 1'b0, 0, 1'b0);
        run_load(3,   0, 1, 1'b0, 0, 1'b0);
        run_load(5,   1, 0, 1'b0, 0, 1'b0);
        run_load(4,   0, 0, 1'b0, 5, 1'b0);
        run_load(4,   0, 0, 1'b1, 0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run_load(int'($urandom_range(0, 70)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)) == 1 ? 2 : 0, 1'b0, 0, 1'b0);
        end
        run_load(1, 2, 2, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
